// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment scanner: prescaled digit slots with leading
// blank cycles, frame-synchronous double-buffered display data, and leading-zero suppression.
module sevenseg_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        lzs,
  output logic [3:0]  bin,
  output logic [3:0]  digit_en_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic          pend_flag_q, pend_flag_d;
  logic [3:0]    bin_q, bin_d;
  logic [3:0]    en_n_q, en_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_done_q, frame_done_d;

  logic          tick, frame;
  logic [3:0]    nz;
  logic          show;

  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    frame        = tick && (idx_q == 2'd3);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    frame_done_d = frame;

    // Active data only changes at a frame boundary; a coincident load refills pending.
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (frame && pend_flag_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end

    // Outputs are computed from next-state so they move on the same edge as idx.
    bin_d  = act_val_d[{idx_d, 2'b00} +: 4];
    dp_n_d = ~act_dp_d[idx_d];

    for (int k = 0; k < 4; k++) begin
      nz[k] = |act_val_d[4*k +: 4];
    end
    case (idx_d)
      2'd0:    show = 1'b1;
      2'd1:    show = |nz[3:1];
      2'd2:    show = |nz[3:2];
      default: show = nz[3];
    endcase
    if (!lzs) show = 1'b1;

    en_n_d = 4'b1111;
    if ((cnt_d >= BLANK) && show) en_n_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_flag_q  <= 1'b0;
      act_val_q    <= 16'h0000;
      act_dp_q     <= 4'h0;
      bin_q        <= 4'h0;
      en_n_q       <= 4'b1111;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      bin_q        <= bin_d;
      en_n_q       <= en_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bin        = bin_q;
  assign digit_en_n = en_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with CLK_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;
  logic        lzs = 1'b0;
  logic [3:0]  bin;
  logic [3:0]  digit_en_n;
  logic        dp_n;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  sevenseg_scan #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .lzs(lzs),
    .bin(bin), .digit_en_n(digit_en_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge where frame_done is high (cycle 0 of slot 0).
  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s frame_done timeout: got %b after %0d cycles, need 1", tag, frame_done, n);
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bin !== 4'h0 || digit_en_n !== 4'b1111 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got bin=%h en=%b dp_n=%b fd=%b need 0 1111 1 0",
               bin, digit_en_n, dp_n, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] v = 16'h1234;
    logic [3:0] eb, ee;
    int s, j;
    load_word(v, 4'b0000);
    wait_fd("basic");
    for (int c = 0; c < 32; c++) begin
      s = c / 8; j = c % 8;
      eb = v[4*s +: 4];
      ee = (j < 2) ? 4'b1111 : ~(4'b0001 << s);
      total++;
      if (bin !== eb || digit_en_n !== ee || dp_n !== 1'b1 || frame_done !== (c == 0)) begin
        bad++;
        $display("FAIL basic c=%0d got bin=%h en=%b dp_n=%b fd=%b need bin=%h en=%b dp_n=1 fd=%b",
                 c, bin, digit_en_n, dp_n, frame_done, eb, ee, (c == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    logic [3:0] eb, ee;
    int s, j;
    wait_fd("b2b");
    load_word(16'hABCD, 4'b0000);
    load_word(16'h5678, 4'b0000);
    for (int c = 2; c < 64; c++) begin
      v = (c < 32) ? 16'h1234 : 16'h5678;
      s = (c % 32) / 8; j = c % 8;
      eb = v[4*s +: 4];
      ee = (j < 2) ? 4'b1111 : ~(4'b0001 << s);
      total++;
      if (bin !== eb || digit_en_n !== ee || frame_done !== (c == 32)) begin
        bad++;
        $display("FAIL b2b c=%0d got bin=%h en=%b fd=%b need bin=%h en=%b fd=%b",
                 c, bin, digit_en_n, frame_done, eb, ee, (c == 32));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundary_load;
    logic [15:0] v;
    logic [3:0] eb;
    int s;
    wait_fd("bnd");
    load_word(16'h2468, 4'b0000);
    repeat (30) @(negedge clk);
    total++;
    if (bin !== 4'h5 || digit_en_n !== 4'b0111) begin
      bad++;
      $display("FAIL bnd_pre got bin=%h en=%b need bin=5 en=0111", bin, digit_en_n);
    end
    value = 16'h1357;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      v = (c < 32) ? 16'h2468 : 16'h1357;
      s = (c % 32) / 8;
      eb = v[4*s +: 4];
      total++;
      if (bin !== eb || frame_done !== (c % 32 == 0)) begin
        bad++;
        $display("FAIL bnd c=%0d got bin=%h fd=%b need bin=%h fd=%b",
                 c, bin, frame_done, eb, (c % 32 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lzs;
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0500};
    logic [3:0]  masks[3] = '{4'b0001, 4'b0001, 4'b0111};
    logic [3:0] eb, ee;
    int s, j;
    lzs = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_fd("lzs");
      load_word(vals[t], 4'b0000);
      wait_fd("lzs");
      for (int c = 0; c < 32; c++) begin
        s = c / 8; j = c % 8;
        eb = vals[t][4*s +: 4];
        ee = (j < 2 || !masks[t][s]) ? 4'b1111 : ~(4'b0001 << s);
        total++;
        if (bin !== eb || digit_en_n !== ee) begin
          bad++;
          $display("FAIL lzs v=%h c=%0d got bin=%h en=%b need bin=%h en=%b",
                   vals[t], c, bin, digit_en_n, eb, ee);
        end
        @(negedge clk);
      end
    end
    lzs = 1'b0;
  endtask

  task automatic test_dp;
    int s;
    wait_fd("dp");
    load_word(16'h1234, 4'b0100);
    wait_fd("dp");
    for (int c = 0; c < 32; c++) begin
      s = c / 8;
      total++;
      if (dp_n !== (s != 2)) begin
        bad++;
        $display("FAIL dp c=%0d got dp_n=%b need %b", c, dp_n, (s != 2));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] ee;
    int s, j;
    wait_fd("rstmid");
    load_word(16'hFFFF, 4'b1111);
    repeat (17) @(negedge clk);
    total++;
    if (digit_en_n !== 4'b1011 || bin !== 4'h2 || dp_n !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre got en=%b bin=%h dp_n=%b need 1011 2 0", digit_en_n, bin, dp_n);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bin !== 4'h0 || digit_en_n !== 4'b1111 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got bin=%h en=%b dp_n=%b fd=%b need 0 1111 1 0",
               bin, digit_en_n, dp_n, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      s = (c % 32) / 8; j = c % 8;
      ee = (j < 2) ? 4'b1111 : ~(4'b0001 << s);
      total++;
      if (bin !== 4'h0 || digit_en_n !== ee || dp_n !== 1'b1 || frame_done !== (c == 32)) begin
        bad++;
        $display("FAIL rstmid c=%0d got bin=%h en=%b dp_n=%b fd=%b need bin=0 en=%b dp_n=1 fd=%b",
                 c, bin, digit_en_n, dp_n, frame_done, ee, (c == 32));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_boundary_load;
    test_lzs;
    test_dp;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
